lane_judge: RTL and testbench
=============================

# lane_judge

Event source for the player life/money block. It runs two falling-target lanes during play states 1–4 and judges the player's two push-buttons against the bottom slot of each lane. It emits the single-cycle hit_0/hit_1 and damage_0/damage_1 pulses that the life/money block consumes, and exposes the lane contents for LED rendering. It sits between the board buttons and the player block, in the same clock domain.

## Interface
- TICK_DIV, 16'd50000: clock cycles per lane step at state 1; 1024 for simulation; minimum 16.
- LANE_DEPTH, 8: slots per lane; slot 0 is the bottom (judge) slot.
- LFSR_SEED, 16'hACE1: spawn LFSR reset value; a seed of 0 is replaced by 16'h0001.

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- state  in  4  game state: 0 idle, 1–4 play levels, 5 failure, others treated as idle
- btn_0  in  1  raw lane-0 button, asynchronous
- btn_1  in  1  raw lane-1 button, asynchronous
- hit_0  out  1  one-cycle pulse: lane-0 target hit
- hit_1  out  1  one-cycle pulse: lane-1 target hit
- damage_0  out  1  one-cycle pulse: lane-0 target missed (1 life)
- damage_1  out  1  one-cycle pulse: lane-1 target missed (2 lives, weighted downstream)
- lane_0  out  LANE_DEPTH  lane-0 occupancy, bit i = slot i
- lane_1  out  LANE_DEPTH  lane-1 occupancy

## Operation
- Play = state ∈ {1,2,3,4}. Outside play:
  - lanes cleared
  - tick counter = 0
  - LFSR holds
  - all pulses 0
  - button edges discarded
- Step period P = TICK_DIV >> (state−1), i.e. TICK_DIV, /2, /4, /8.
- Tick counter counts 0..P−1. step = (count == P−1), after which count returns to 0.
- Counter clears to 0 whenever state differs from the previous cycle's registered state, including a level change inside play.
- On step:
  - LFSR (x^16+x^14+x^13+x^11+1, Fibonacci, shift right) advances once.
  - spawn_0 = lfsr[1:0]==2'b11 and spawn_1 = lfsr[3:2]==2'b11, taken from the pre-advance value.
  - Each lane shifts: lane ← {spawn, lane[LANE_DEPTH−1:1]}.
  - The shifted-out bit 0, if still set after this cycle's judging, produces a damage pulse for that lane.
- Buttons: 2-flop synchronizer, then a rising-edge detect (sync2 & ~sync3). Holding a button gives one edge only.
- Judging per lane, on a cycle with an edge:
  - lane[0]==1: hit pulse, and bit 0 is cleared in the same update.
  - lane[0]==0: no pulse and no penalty.
- Edge and step on the same cycle: judge first, then shift. A hit suppresses that slot's damage, and only hit is pulsed.
- Lanes are independent. All four pulses may assert in the same cycle.
- hit_x and damage_x are mutually exclusive per lane per cycle.

## Timing
- Reset values:
  - all outputs 0
  - lane_0 = lane_1 = 0
  - counter 0
  - LFSR = seed
  - synchronizer flops 0
  - previous-state register 0
- All outputs are registered. Each pulse is high for exactly one cycle.
- Button latency: btn sampled high at edge N → sync2 high after N+1 → hit pulse high for the cycle after edge N+2.
- Step latency:
  - First step occurs at the P-th rising edge after play is entered.
  - Damage pulse and the shifted lane appear after that same edge.
- Leaving play mid-step clears the lanes at the next edge. No damage is emitted for targets still in the lanes.
- rst mid-play returns everything to reset values immediately (asynchronous).

## Structure
- Package lane_pkg:
  - state constants S_IDLE=0, S_PLAY1..S_PLAY4=1..4, S_FAIL=5
  - LANE_DEPTH default
  - LFSR tap mask
  - function is_play(state)
- Sub-module btn_edge (2-flop synchronizer + edge register, output one-cycle rise), instantiated twice.
- Top holds the tick counter, LFSR, lanes, judge logic and output registers.

## Test plan
- Reset, then state=1, TICK_DIV=16, no buttons.
  - First step after edge 16, next after edge 32.
  - lane_x tracks the bench LFSR model.
  - A target reaching slot 0 pulses damage_x one cycle on the following step.
  - Seed 0 behaves as seed 1.
- Lane 0 slot 0 occupied, btn_0 rises at edge N.
  - hit_0 high exactly for the cycle after N+2, and lane_0[0] clears.
  - No damage_0 at the next step.
  - Holding the button gives no second hit.
- btn_1 pressed with lane_1[0]==0.
  - No pulses, and the lane is unchanged.
  - btn_1 edge landing on a step cycle with lane_1[0]==1 gives hit_1 only, never damage_1.
- state 1→4 mid-count.
  - Counter clears, and the next step comes 2 cycles later (16>>3).
  - state→5: lanes read 0 next cycle, no pulses while in state 5.
- Both lanes occupied at slot 0, both buttons pressed together.
  - hit_0 and hit_1 in the same cycle.
  - Assert rst mid-play: outputs 0 immediately, LFSR back to seed.

Source files
------------

// File: rtl/lane_judge_pkg.sv
// Shared constants for the falling-target lane judge: game state codes,
// default lane depth and the spawn LFSR feedback taps.
package lane_pkg;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_PLAY1 = 4'd1,
      S_PLAY2 = 4'd2,
      S_PLAY3 = 4'd3,
      S_PLAY4 = 4'd4,
      S_FAIL  = 4'd5
   } state_e;

   localparam int LANE_DEPTH_DEF = 8;

   // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic is_play(input logic [3:0] s);
      return (s >= 4'(S_PLAY1)) && (s <= 4'(S_PLAY4));
   endfunction

endpackage

// File: rtl/lane_judge_btn_edge.sv
// Button conditioning: two-flop synchronizer plus one extra stage so that a
// press produces a single-cycle rise no matter how long it is held.
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);

   logic [2:0] sync_q;
   logic [2:0] sync_d;

   always_comb begin
      sync_d = {sync_q[1:0], btn};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/lane_judge.sv
// Two falling-target lanes stepped by a level-scaled tick, judged against the
// player's buttons; emits registered hit/damage pulses and lane occupancy.
module lane_judge
   import lane_pkg::*;
#(
   parameter logic [15:0] TICK_DIV   = 16'd50000,
   parameter int          LANE_DEPTH = LANE_DEPTH_DEF,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            state,
   input  logic                  btn_0,
   input  logic                  btn_1,
   output logic                  hit_0,
   output logic                  hit_1,
   output logic                  damage_0,
   output logic                  damage_1,
   output logic [LANE_DEPTH-1:0] lane_0,
   output logic [LANE_DEPTH-1:0] lane_1
);

   localparam logic [15:0] SEED = (LFSR_SEED == 16'd0) ? 16'h0001 : LFSR_SEED;

   logic [3:0]  prev_state_q, prev_state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [15:0] period;
   logic [15:0] cnt_eff;
   logic        play;
   logic        step;
   logic [1:0]  btn_vec;

   assign btn_vec = {btn_1, btn_0};

   // A state change (entry to play or a level change) restarts the count on
   // the very edge that observes it, so the first step lands on edge P.
   always_comb begin
      play         = is_play(state);
      period       = TICK_DIV >> (state[1:0] - 2'd1);
      cnt_eff      = (state != prev_state_q) ? 16'd0 : cnt_q;
      step         = play && (cnt_eff == period - 16'd1);
      prev_state_d = state;
      cnt_d        = 16'd0;
      lfsr_d       = lfsr_q;
      if (play) begin
         cnt_d = step ? 16'd0 : cnt_eff + 16'd1;
         if (step) begin
            lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_state_q <= 4'd0;
         cnt_q        <= 16'd0;
         lfsr_q       <= SEED;
      end else begin
         prev_state_q <= prev_state_d;
         cnt_q        <= cnt_d;
         lfsr_q       <= lfsr_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         logic                  rise;
         logic                  spawn;
         logic [LANE_DEPTH-1:0] judged;
         logic [LANE_DEPTH-1:0] lane_q, lane_d;
         logic                  hit_q, hit_d;
         logic                  dmg_q, dmg_d;

         btn_edge u_edge (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_vec[gi]),
            .rise (rise)
         );

         assign spawn = (lfsr_q[2*gi +: 2] == 2'b11);

         // Judge before shifting so a hit on a step cycle removes the target
         // before it can fall out as damage.
         always_comb begin
            judged = lane_q;
            hit_d  = 1'b0;
            dmg_d  = 1'b0;
            lane_d = '0;
            if (play) begin
               if (rise && lane_q[0]) begin
                  hit_d     = 1'b1;
                  judged[0] = 1'b0;
               end
               if (step) begin
                  dmg_d  = judged[0];
                  lane_d = {spawn, judged[LANE_DEPTH-1:1]};
               end else begin
                  lane_d = judged;
               end
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               lane_q <= '0;
               hit_q  <= 1'b0;
               dmg_q  <= 1'b0;
            end else begin
               lane_q <= lane_d;
               hit_q  <= hit_d;
               dmg_q  <= dmg_d;
            end
         end
      end
   endgenerate

   assign lane_0   = g_lane[0].lane_q;
   assign lane_1   = g_lane[1].lane_q;
   assign hit_0    = g_lane[0].hit_q;
   assign hit_1    = g_lane[1].hit_q;
   assign damage_0 = g_lane[0].dmg_q;
   assign damage_1 = g_lane[1].dmg_q;

endmodule

// File: tb/tb_lane_judge.sv
// Randomized bench for lane_judge: two instances (normal seed and seed 0)
// compared every cycle against a slot-array model of the lane rules.
module tb_lane_judge;

   localparam int D = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   state;
   logic         btn_0, btn_1;

   logic         a_hit0, a_hit1, a_dmg0, a_dmg1;
   logic [D-1:0] a_lane0, a_lane1;
   logic         b_hit0, b_hit1, b_dmg0, b_dmg1;
   logic [D-1:0] b_lane0, b_lane1;

   always #5 clk = ~clk;

   lane_judge #(.TICK_DIV(16'd16), .LANE_DEPTH(D), .LFSR_SEED(16'hACE1)) dut_a (
      .clk(clk), .rst(rst), .state(state), .btn_0(btn_0), .btn_1(btn_1),
      .hit_0(a_hit0), .hit_1(a_hit1), .damage_0(a_dmg0), .damage_1(a_dmg1),
      .lane_0(a_lane0), .lane_1(a_lane1)
   );

   lane_judge #(.TICK_DIV(16'd16), .LANE_DEPTH(D), .LFSR_SEED(16'h0000)) dut_b (
      .clk(clk), .rst(rst), .state(state), .btn_0(btn_0), .btn_1(btn_1),
      .hit_0(b_hit0), .hit_1(b_hit1), .damage_0(b_dmg0), .damage_1(b_dmg1),
      .lane_0(b_lane0), .lane_1(b_lane1)
   );

   // Reference model: index [inst][lane][slot]; inst 1 is the seed-0 copy
   bit [15:0]  m_lfsr [2];
   bit         m_slot [2][2][D];
   bit         e_hit  [2][2];
   bit         e_dmg  [2][2];
   int         m_k;
   logic [3:0] m_prev;
   bit         hist0[$];
   bit         hist1[$];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int period_of(input logic [3:0] s);
      int lvl;
      lvl = int'(s) - 1;
      return 16 >> lvl;
   endfunction

   function automatic logic [D-1:0] lane_vec(input int inst, input int l);
      logic [D-1:0] v;
      for (int s = 0; s < D; s++) v[s] = m_slot[inst][l][s];
      return v;
   endfunction

   task automatic model_reset();
      m_lfsr[0] = 16'hACE1;
      m_lfsr[1] = 16'h0001;
      for (int i = 0; i < 2; i++)
         for (int l = 0; l < 2; l++) begin
            e_hit[i][l] = 1'b0;
            e_dmg[i][l] = 1'b0;
            for (int s = 0; s < D; s++) m_slot[i][l][s] = 1'b0;
         end
      m_k    = 0;
      m_prev = 4'd0;
      hist0  = {1'b0, 1'b0, 1'b0};
      hist1  = {1'b0, 1'b0, 1'b0};
   endtask

   // One rising edge: a press sampled at edge E-2 that was low at E-3 is
   // judged at edge E; steps fall on every P-th edge spent in the state.
   task automatic model_edge();
      bit ed [2];
      bit play;
      bit stp;
      bit spawn;
      bit fb;
      ed[0] = hist0[hist0.size()-2] && !hist0[hist0.size()-3];
      ed[1] = hist1[hist1.size()-2] && !hist1[hist1.size()-3];
      hist0.push_back(btn_0);
      hist1.push_back(btn_1);
      void'(hist0.pop_front());
      void'(hist1.pop_front());

      if (state != m_prev) m_k = 1;
      else m_k++;
      m_prev = state;

      play = (state >= 4'd1) && (state <= 4'd4);
      for (int i = 0; i < 2; i++) begin
         for (int l = 0; l < 2; l++) begin
            e_hit[i][l] = 1'b0;
            e_dmg[i][l] = 1'b0;
         end
         if (!play) begin
            for (int l = 0; l < 2; l++)
               for (int s = 0; s < D; s++) m_slot[i][l][s] = 1'b0;
         end else begin
            stp = (m_k % period_of(state)) == 0;
            for (int l = 0; l < 2; l++) begin
               if (ed[l] && m_slot[i][l][0]) begin
                  e_hit[i][l]     = 1'b1;
                  m_slot[i][l][0] = 1'b0;
               end
               if (stp) begin
                  spawn = (m_lfsr[i][2*l] == 1'b1) && (m_lfsr[i][2*l+1] == 1'b1);
                  e_dmg[i][l] = m_slot[i][l][0];
                  for (int s = 0; s < D-1; s++) m_slot[i][l][s] = m_slot[i][l][s+1];
                  m_slot[i][l][D-1] = spawn;
               end
            end
            if (stp) begin
               fb = m_lfsr[i][0] ^ m_lfsr[i][2] ^ m_lfsr[i][3] ^ m_lfsr[i][5];
               m_lfsr[i] = {fb, m_lfsr[i][15:1]};
            end
         end
      end
   endtask

   task automatic compare_all();
      check("a_hit0",  a_hit0,  e_hit[0][0]);
      check("a_hit1",  a_hit1,  e_hit[0][1]);
      check("a_dmg0",  a_dmg0,  e_dmg[0][0]);
      check("a_dmg1",  a_dmg1,  e_dmg[0][1]);
      check("a_lane0", a_lane0, lane_vec(0, 0));
      check("a_lane1", a_lane1, lane_vec(0, 1));
      check("b_hit0",  b_hit0,  e_hit[1][0]);
      check("b_hit1",  b_hit1,  e_hit[1][1]);
      check("b_dmg0",  b_dmg0,  e_dmg[1][0]);
      check("b_dmg1",  b_dmg1,  e_dmg[1][1]);
      check("b_lane0", b_lane0, lane_vec(1, 0));
      check("b_lane1", b_lane1, lane_vec(1, 1));
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!rst) model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic run(input logic [3:0] st, input int n, input bit rnd);
      state = st;
      for (int c = 0; c < n; c++) begin
         if (rnd) begin
            if ($urandom_range(0, 3) == 0) btn_0 = ~btn_0;
            if ($urandom_range(0, 3) == 0) btn_1 = ~btn_1;
         end
         cycle();
      end
   endtask

   initial begin
      rst   = 1'b1;
      state = 4'd0;
      btn_0 = 1'b0;
      btn_1 = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      rst = 1'b0;

      run(4'd0, 3, 1'b0);
      run(4'd1, 80, 1'b0);
      run(4'd1, 300, 1'b1);
      run(4'd4, 150, 1'b1);
      run(4'd5, 20, 1'b1);
      run(4'd2, 150, 1'b1);
      run(4'd3, 90, 1'b1);

      // Asynchronous reset in the middle of play
      rst = 1'b1;
      model_reset();
      #1;
      compare_all();
      cycle();
      cycle();
      rst = 1'b0;

      run(4'd3, 120, 1'b1);
      run(4'd7, 10, 1'b1);
      run(4'd1, 60, 1'b1);
      run(4'd4, 60, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
